// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction-fetch controller with IF/ID output register
//
// Sequences a byte-addressed, combinationally read instruction memory.
// It owns the PC and delivers each fetched word to decode over a
// valid/ready handshake. Execute can redirect it with a branch or jump
// target. It stops at the end of the memory image and faults on
// misaligned redirect targets.
//
// Ports:
//   clk             - single clock, rising edge
//   reset           - asynchronous, active-low reset
//   start           - begin fetching (sampled only in IDLE)
//   Inst_Address    - current PC, drives the memory address
//   Instruction     - memory read data for Inst_Address (same cycle)
//   if_valid        - output register holds an undelivered instruction
//   if_ready        - decode accepts the held instruction
//   if_pc           - PC of the held instruction
//   if_instr        - the held instruction
//   redirect_valid  - single-cycle redirect request from execute
//   redirect_target - new PC for the redirect
//   fetch_count     - completed transfers, saturating
//   done            - end of image reached and output register drained
//   fault           - misaligned redirect seen (sticky until reset)
module fetch_sequencer #(
  parameter int          MEM_BYTES = 16,
  parameter logic [63:0] RESET_PC  = 64'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [63:0] Inst_Address,
  input  logic [31:0] Instruction,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [63:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_target,
  output logic [15:0] fetch_count,
  output logic        done,
  output logic        fault
);

  // Highest PC whose full word still lies inside the memory image.
  localparam logic [63:0] LAST_PC = 64'(MEM_BYTES) - 64'd4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_DRAIN = 3'd2,
    S_DONE  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic        if_valid_q, if_valid_d;
  logic [63:0] if_pc_q, if_pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic [15:0] fetch_count_q, fetch_count_d;
  logic        done_q, done_d;
  logic        fault_q, fault_d;

  logic xfer;
  logic le;
  logic in_range;
  logic redirect_aligned;

  assign xfer             = if_valid_q && if_ready;
  // The output register may take a new word when it is empty or being drained.
  assign le               = !if_valid_q || if_ready;
  // Full 64-bit compare, so far-away redirect targets count as out of range.
  assign in_range         = (pc_q <= LAST_PC);
  assign redirect_aligned = (redirect_target[1:0] == 2'b00);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      if_valid_q    <= 1'b0;
      if_pc_q       <= 64'd0;
      if_instr_q    <= 32'd0;
      fetch_count_q <= 16'd0;
      done_q        <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      if_valid_q    <= if_valid_d;
      if_pc_q       <= if_pc_d;
      if_instr_q    <= if_instr_d;
      fetch_count_q <= fetch_count_d;
      done_q        <= done_d;
      fault_q       <= fault_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    if_valid_d    = if_valid_q;
    if_pc_d       = if_pc_q;
    if_instr_d    = if_instr_q;
    fetch_count_d = fetch_count_q;
    done_d        = done_q;
    fault_d       = fault_q;

    // A transfer always counts, even when a redirect flushes in the same
    // cycle: decode has already consumed the word.
    if (xfer && (fetch_count_q != 16'hFFFF)) begin
      fetch_count_d = fetch_count_q + 16'd1;
    end

    if (state_q != S_FAULT && redirect_valid) begin
      // Redirects take priority over any capture in this cycle.
      if (!redirect_aligned) begin
        if_valid_d = 1'b0;
        done_d     = 1'b0;
        fault_d    = 1'b1;
        state_d    = S_FAULT;
      end else if (state_q == S_IDLE) begin
        pc_d = redirect_target;
      end else begin
        pc_d       = redirect_target;
        if_valid_d = 1'b0;
        done_d     = 1'b0;
        state_d    = S_FETCH;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_FETCH;
          end
        end
        S_FETCH: begin
          if (in_range) begin
            if (le) begin
              if_pc_d    = pc_q;
              if_instr_d = Instruction;
              if_valid_d = 1'b1;
              pc_d       = pc_q + 64'd4;
            end
          end else begin
            if (xfer) begin
              if_valid_d = 1'b0;
            end
            state_d = S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (xfer) begin
            if_valid_d = 1'b0;
          end
          if (!if_valid_q || xfer) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
        S_DONE: begin
          done_d = 1'b1;
        end
        S_FAULT: begin
          if_valid_d = 1'b0;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign Inst_Address = pc_q;
  assign if_valid     = if_valid_q;
  assign if_pc        = if_pc_q;
  assign if_instr     = if_instr_q;
  assign fetch_count  = fetch_count_q;
  assign done         = done_q;
  assign fault        = fault_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed self-checking bench for fetch_sequencer
module tb_fetch_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [63:0] Inst_Address;
  logic [31:0] Instruction;
  logic        if_valid;
  logic        if_ready;
  logic [63:0] if_pc;
  logic [31:0] if_instr;
  logic        redirect_valid;
  logic [63:0] redirect_target;
  logic [15:0] fetch_count;
  logic        done;
  logic        fault;

  int checks   = 0;
  int failures = 0;

  logic [31:0] image [4];

  fetch_sequencer #(.MEM_BYTES(16), .RESET_PC(64'd0)) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .Inst_Address    (Inst_Address),
    .Instruction     (Instruction),
    .if_valid        (if_valid),
    .if_ready        (if_ready),
    .if_pc           (if_pc),
    .if_instr        (if_instr),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .fetch_count     (fetch_count),
    .done            (done),
    .fault           (fault)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_comb begin
    if (Inst_Address < 64'd16) Instruction = image[Inst_Address[3:2]];
    else                       Instruction = 32'hDEAD_BEEF;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic async_reset();
    #2;
    reset = 1'b0;
    #1;
    reset = 1'b1;
  endtask

  initial begin
    image[0] = 32'h01BD0CB3;
    image[1] = 32'h017C8D33;
    image[2] = 32'h01AD8BB3;
    image[3] = 32'h01AB8DB3;
    reset = 1'b0;
    start = 1'b0;
    if_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_target = 64'd0;

    // Reset state
    step();
    chk("rst_addr", Inst_Address, 64'd0);
    chk("rst_valid", {63'd0, if_valid}, 64'd0);
    chk("rst_pc", if_pc, 64'd0);
    chk("rst_instr", {32'd0, if_instr}, 64'd0);
    chk("rst_count", {48'd0, fetch_count}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_fault", {63'd0, fault}, 64'd0);
    reset = 1'b1;

    // Streaming fetch of the 4-word image
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t1_k_valid", {63'd0, if_valid}, 64'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t1_valid", {63'd0, if_valid}, 64'd1);
      chk("t1_pc", if_pc, 64'(4 * i));
      chk("t1_instr", {32'd0, if_instr}, {32'd0, image[i]});
      chk("t1_count", {48'd0, fetch_count}, 64'(i));
    end
    chk("t1_addr_end", Inst_Address, 64'd16);
    step();
    chk("t1_n1_valid", {63'd0, if_valid}, 64'd0);
    chk("t1_n1_done", {63'd0, done}, 64'd0);
    chk("t1_n1_count", {48'd0, fetch_count}, 64'd4);
    step();
    chk("t1_done", {63'd0, done}, 64'd1);
    chk("t1_count", {48'd0, fetch_count}, 64'd4);

    // Redirect to 0 from DONE: refetch, count continues to 8
    redirect_valid = 1'b1;
    redirect_target = 64'd0;
    step();
    redirect_valid = 1'b0;
    chk("t5_done_clr", {63'd0, done}, 64'd0);
    chk("t5_valid", {63'd0, if_valid}, 64'd0);
    chk("t5_addr", Inst_Address, 64'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t5_pc", if_pc, 64'(4 * i));
      chk("t5_count", {48'd0, fetch_count}, 64'(4 + i));
    end
    step();
    chk("t5_n1_count", {48'd0, fetch_count}, 64'd8);
    step();
    chk("t5_done", {63'd0, done}, 64'd1);

    // Asynchronous reset mid-stream
    async_reset();
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    chk("t6_pre_valid", {63'd0, if_valid}, 64'd1);
    chk("t6_pre_count", {48'd0, fetch_count}, 64'd2);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_valid", {63'd0, if_valid}, 64'd0);
    chk("t6_count", {48'd0, fetch_count}, 64'd0);
    chk("t6_done", {63'd0, done}, 64'd0);
    chk("t6_fault", {63'd0, fault}, 64'd0);
    chk("t6_addr", Inst_Address, 64'd0);
    reset = 1'b1;
    step();
    step();
    step();
    chk("t6_idle_valid", {63'd0, if_valid}, 64'd0);
    chk("t6_idle_addr", Inst_Address, 64'd0);
    chk("t6_idle_count", {48'd0, fetch_count}, 64'd0);

    // Stall for 3 cycles on the second word
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("t2_pc0", if_pc, 64'd0);
    step();
    chk("t2_pc4", if_pc, 64'd4);
    if_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t2_hold_pc", if_pc, 64'd4);
      chk("t2_hold_instr", {32'd0, if_instr}, 64'h017C8D33);
      chk("t2_hold_addr", Inst_Address, 64'd8);
      chk("t2_hold_valid", {63'd0, if_valid}, 64'd1);
      chk("t2_hold_count", {48'd0, fetch_count}, 64'd1);
    end
    if_ready = 1'b1;
    step();
    chk("t2_pc8", if_pc, 64'd8);
    chk("t2_count2", {48'd0, fetch_count}, 64'd2);
    step();
    chk("t2_pc12", if_pc, 64'd12);
    chk("t2_count3", {48'd0, fetch_count}, 64'd3);
    step();
    chk("t2_count4", {48'd0, fetch_count}, 64'd4);
    step();
    chk("t2_done", {63'd0, done}, 64'd1);
    chk("t2_final", {48'd0, fetch_count}, 64'd4);

    // Redirect to 12 coincident with transfer of the PC 0 word
    async_reset();
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("t3_pc0", if_pc, 64'd0);
    chk("t3_valid0", {63'd0, if_valid}, 64'd1);
    redirect_valid = 1'b1;
    redirect_target = 64'd12;
    step();
    redirect_valid = 1'b0;
    chk("t3_bubble", {63'd0, if_valid}, 64'd0);
    chk("t3_count1", {48'd0, fetch_count}, 64'd1);
    chk("t3_addr", Inst_Address, 64'd12);
    step();
    chk("t3_valid12", {63'd0, if_valid}, 64'd1);
    chk("t3_pc12", if_pc, 64'd12);
    chk("t3_instr12", {32'd0, if_instr}, 64'h01AB8DB3);
    step();
    chk("t3_count2", {48'd0, fetch_count}, 64'd2);
    step();
    chk("t3_done", {63'd0, done}, 64'd1);
    chk("t3_final", {48'd0, fetch_count}, 64'd2);

    // Misaligned redirect to 6 in FETCH
    async_reset();
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    if_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_target = 64'd6;
    step();
    redirect_valid = 1'b0;
    chk("t4_fault", {63'd0, fault}, 64'd1);
    chk("t4_valid", {63'd0, if_valid}, 64'd0);
    if_ready = 1'b1;
    start = 1'b1;
    redirect_valid = 1'b1;
    redirect_target = 64'd0;
    step();
    step();
    start = 1'b0;
    redirect_valid = 1'b0;
    step();
    chk("t4_fault_sticky", {63'd0, fault}, 64'd1);
    chk("t4_ignored_valid", {63'd0, if_valid}, 64'd0);
    chk("t4_ignored_count", {48'd0, fetch_count}, 64'd0);
    chk("t4_ignored_done", {63'd0, done}, 64'd0);
    #2;
    reset = 1'b0;
    #1;
    chk("t4_reset_fault", {63'd0, fault}, 64'd0);
    chk("t4_reset_addr", Inst_Address, 64'd0);
    reset = 1'b1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
